// File: rtl/desc_mem_arbiter.sv
// desc_mem_arbiter
// Round-robin arbiter sharing the single-port descriptor RAM between the
// control CPU (m0) and the DMA descriptor engine (m1). At most one RAM
// access per cycle; read data returns with a fixed one-cycle latency.
// Optional bus locking is compiled in with `define DESC_MEM_ARB_LOCK_EN.
module desc_mem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        LOCKED_M0 = 2'd1,
        LOCKED_M1 = 2'd2
    } lock_state_e;

    lock_state_e          state_q;

    logic                 m0_req;
    logic                 m1_req;
    logic                 gnt0;
    logic                 gnt1;
    logic                 issue;
    logic                 issue_write;

    // last_grant_q: 0 = m0 was granted last, 1 = m1 was granted last
    logic                 last_grant_q;
    logic                 last_grant_d;

    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    addr_d;
    logic [BE_W-1:0]      be_q;
    logic [BE_W-1:0]      be_d;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    wdata_d;

    logic                 pend_q;
    logic                 pend_d;
    logic                 pend_owner_q;
    logic                 pend_owner_d;

    logic [DATA_W-1:0]    rdata0_q;
    logic [DATA_W-1:0]    rdata0_d;
    logic [DATA_W-1:0]    rdata1_q;
    logic [DATA_W-1:0]    rdata1_d;
    logic                 rdv0;
    logic                 rdv1;

    // A simultaneous read and write is treated as a write
    always_comb begin
        m0_req = m0_read | m0_write;
        m1_req = m1_read | m1_write;
    end

`ifdef DESC_MEM_ARB_LOCK_EN
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

    lock_state_e          state_d;
    logic [TMO_W-1:0]     tmo_q;
    logic [TMO_W-1:0]     tmo_d;
    logic                 issue_lock;

    // Lock request of whichever master is issuing this cycle
    always_comb begin
        issue_lock = gnt1 ? m1_lock : m0_lock;
    end

    // Lock state and timeout counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UNLOCKED;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Lock next-state: enter on a locked issue, leave on an unlocked owner
    // issue or when the owner has been silent for LOCK_TIMEOUT cycles
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            UNLOCKED: begin
                if (issue && issue_lock) begin
                    state_d = gnt1 ? LOCKED_M1 : LOCKED_M0;
                    tmo_d   = '0;
                end
            end
            LOCKED_M0, LOCKED_M1: begin
                // While locked only the owner can be granted, so any issue
                // is an owner transfer
                if (issue) begin
                    tmo_d = '0;
                    if (!issue_lock) begin
                        state_d = UNLOCKED;
                    end
                end else if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = UNLOCKED;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = UNLOCKED;
                tmo_d   = '0;
            end
        endcase
    end
`else
    logic unused_lock;

    // Without locking the arbiter is permanently unlocked
    always_comb begin
        state_q     = UNLOCKED;
        unused_lock = m0_lock ^ m1_lock ^ (LOCK_TIMEOUT > 0);
    end
`endif

    // Grant selection: lock owner only, else round-robin on contention
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            case (state_q)
                LOCKED_M0: gnt0 = m0_req;
                LOCKED_M1: gnt1 = m1_req;
                default: begin
                    if (m0_req && m1_req) begin
                        gnt0 = last_grant_q;
                        gnt1 = !last_grant_q;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                end
            endcase
        end
    end

    // Stall outputs and RAM-side drive for the issuing master
    always_comb begin
        issue          = gnt0 | gnt1;
        issue_write    = gnt1 ? m1_write : m0_write;

        m0_waitrequest = !reset_n || (state_q == LOCKED_M1) || (m0_req && !gnt0);
        m1_waitrequest = !reset_n || (state_q == LOCKED_M0) || (m1_req && !gnt1);

        mem_clken      = reset_n;
        mem_chipselect = issue;
        mem_write      = issue && issue_write;
        mem_address    = addr_q;
        mem_byteenable = be_q;
        mem_writedata  = wdata_q;
        if (issue) begin
            mem_address    = gnt1 ? m1_address    : m0_address;
            mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
            mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
        end
    end

    // Next values for held RAM fields, round-robin pointer and read tracking
    always_comb begin
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        pend_d       = 1'b0;
        pend_owner_d = pend_owner_q;
        if (issue) begin
            addr_d       = mem_address;
            be_d         = mem_byteenable;
            wdata_d      = mem_writedata;
            last_grant_d = gnt1;
            pend_d       = !issue_write;
            pend_owner_d = gnt1;
        end
    end

    // Held RAM fields, round-robin pointer and pending-read flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
            pend_q       <= 1'b0;
            pend_owner_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            pend_q       <= pend_d;
            pend_owner_q <= pend_owner_d;
        end
    end

    // Read return: RAM output passes straight through in the valid cycle,
    // and is captured so readdata holds afterwards
    always_comb begin
        rdv0             = pend_q && !pend_owner_q;
        rdv1             = pend_q &&  pend_owner_q;
        m0_readdatavalid = rdv0;
        m1_readdatavalid = rdv1;
        m0_readdata      = rdv0 ? mem_readdata : rdata0_q;
        m1_readdata      = rdv1 ? mem_readdata : rdata1_q;
        rdata0_d         = m0_readdata;
        rdata1_d         = m1_readdata;
    end

    // Last returned read word per master
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: doc/desc_mem_arbiter.md
Name: desc_mem_arbiter

Overview:
Two-port Avalon-MM arbiter that shares the single-port 2048x32 descriptor on-chip RAM between two requesters. m0 is the control CPU; m1 is the DMA descriptor fetch/writeback engine. The block issues at most one RAM access per cycle, using round-robin priority. It returns read data with fixed one-cycle latency to whichever master issued the read.

Parameters:
ADDR_W, 11, word address width (2048 words)
DATA_W, 32, data width; byteenable width is DATA_W/8
LOCK_TIMEOUT, 64, cycles a lock may be held without an owner transfer before forced release (only used with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  m0 word address
m0_byteenable  in  DATA_W/8  m0 byte lanes
m0_read  in  1  m0 read request
m0_write  in  1  m0 write request
m0_writedata  in  DATA_W  m0 write data
m0_lock  in  1  m0 lock request (optional feature only; otherwise ignored)
m0_waitrequest  out  1  m0 stall
m0_readdata  out  DATA_W  m0 read data
m0_readdatavalid  out  1  m0 read data valid
m1_*  (same set as m0_*)  identical ports for m1
mem_address  out  ADDR_W  RAM address
mem_byteenable  out  DATA_W/8  RAM byte enables
mem_chipselect  out  1  RAM select
mem_write  out  1  RAM write
mem_writedata  out  DATA_W  RAM write data
mem_clken  out  1  RAM clock enable
mem_readdata  in  DATA_W  RAM output; valid one cycle after the address (registered address, unregistered output)

Behaviour:
- Reset values (reset_n low):
  - m*_waitrequest = 1.
  - m*_readdatavalid = 0.
  - mem_chipselect = 0, mem_write = 0, mem_clken = 0.
  - last_grant = m1, so m0 wins the first contention.
  - No pending reads.
- Request: mX_req = mX_read | mX_write. If read and write are both high, treat it as a write.
- Grant selection is combinational in the same cycle:
  - Only one master requesting: that master is granted.
  - Both requesting: the master that is not last_grant is granted.
- Granted master:
  - Its waitrequest = 0; the other master's waitrequest = 1.
  - A master that is not requesting sees waitrequest = 0, so an idle master is never stalled.
- Issue cycle N: the granted master's address, byteenable and writedata drive mem_*; mem_chipselect = 1; mem_write = granted write.
- With no grant: mem_chipselect = 0; mem_address, mem_byteenable and mem_writedata hold their last values.
- last_grant updates at the clock edge that ends issue cycle N.
- mem_clken = 1 whenever reset_n is high.
- Read return:
  - A read issued in cycle N sets mX_readdatavalid = 1 in cycle N+1, with mX_readdata = mem_readdata.
  - The other master's readdatavalid stays 0.
  - Registered pending flag: 1 bit plus owner.
- Throughput:
  - Back-to-back issue every cycle is allowed, for reads and writes, from either master.
  - Read latency is always exactly 1 cycle.
- A read issued in cycle N+1 to an address written in cycle N returns the new data; the RAM is single-port, so this is in order.
- mX_readdata holds its last value when readdatavalid is 0.
- Reset asserted mid-operation: the pending read is discarded and readdatavalid stays 0 after reset release.
- Reset is asynchronous assert, synchronous deassert to clk (external synchronizer).
- States (optional feature): UNLOCKED, LOCKED_M0, LOCKED_M1. Without the feature the FSM is UNLOCKED only.

Optional Feature:
DESC_MEM_ARB_LOCK_EN
- Defined:
  - An issued transfer with mX_lock = 1 moves the FSM UNLOCKED -> LOCKED_mX.
  - While locked, only the owner can be granted, and the other master's waitrequest is held at 1.
  - The lock is released (-> UNLOCKED) when the owner issues a transfer with lock = 0. That transfer completes normally.
  - A timeout counter counts cycles with no owner transfer. On reaching LOCK_TIMEOUT it forces UNLOCKED. The counter reloads on every owner transfer.
  - Reset gives UNLOCKED with the counter at 0.
  - A lock release and the other master's request in the same cycle: the other master is granted on the next cycle.
- Undefined:
  - Lock ports are ignored; there is no FSM and no counter.

Test Plan:
- RAM preloaded word 0x005 = 0x12345678; m0 read addr 0x005 -> waitrequest 0 in issue cycle, m0_readdatavalid = 1 next cycle with 0x12345678; m1_readdatavalid = 0.
- m0 and m1 both read continuously from reset (addr 0x010 and 0x020) -> grants alternate m0, m1, m0, …; each master sees readdatavalid every other cycle with the correct data.
- m1 writes 4 consecutive words 0x100..0x103, m0 idle -> 4 issues in 4 cycles, no waitrequest.
- Read back 0x100..0x103 -> data matches.
- Word 0x200 = 0xFFFFFFFF; m0 write 0xAABBCCDD with byteenable 0x3 -> read-back returns 0xFFFFCCDD.
- m1 read issued, reset_n pulsed low in the next cycle -> m1_readdatavalid stays 0; all outputs at reset values.
- With DESC_MEM_ARB_LOCK_EN defined:
  - m0 read with lock = 1, then m1 requests -> m1 stalled until m0 write with lock = 0; m1 granted the following cycle.
  - Repeat with m0 idle after the lock -> m1 granted after 64 cycles (timeout).
